pipe_stage_reg: RTL and testbench

- Generic, parametrised inter-stage pipeline register; successor to the fixed-field ID/EX latch.
- Carries an opaque packed payload (aluop, alusel, operands, wd, wreg, link address, inst, …) of DATA_W bits plus a delay-slot loop-back flag.
- Two modes:
  - MODE=0: driven by the central stall[] vector, as the existing ctrl unit does today.
  - MODE=1: valid/ready handshake with a 2-entry skid buffer, for decoupled stages (e.g. multi-cycle EX units).
- Adds a synchronous flush that the current latches lack.

---
 rtl/pipe_stage_reg_pkg.sv | 40 ++++
 rtl/pipe_skid_buf.sv | 30 +++
 rtl/pipe_stage_reg.sv | 118 +++++++++++
 tb/tb_pipe_stage_reg.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: stall encodings, ID/EX payload layout and its bubble value.
package pipe_stage_reg_pkg;

  localparam int   CTRL_STALL_W = 6;
  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;

  localparam int ALU_OP_W   = 8;
  localparam int ALU_SEL_W  = 3;
  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [ALU_OP_W-1:0]   EXE_NOP_OP   = '0;
  localparam logic [ALU_SEL_W-1:0]  EXE_RES_NOP  = '0;
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

  typedef struct packed {
    logic [ALU_OP_W-1:0]   aluop;
    logic [ALU_SEL_W-1:0]  alusel;
    logic [REG_W-1:0]      reg1;
    logic [REG_W-1:0]      reg2;
    logic [REG_W-1:0]      link_addr;
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
  } id_ex_t;

  localparam int ID_EX_W = $bits(id_ex_t);

  // NOP op, NOP sel, no register write: safe to inject as a bubble
  localparam id_ex_t ID_EX_BUBBLE = '{
    aluop:     EXE_NOP_OP,
    alusel:    EXE_RES_NOP,
    reg1:      '0,
    reg2:      '0,
    link_addr: '0,
    wd:        NOP_REG_ADDR,
    wreg:      1'b0
  };

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid register with valid; clr and rst both empty it.
// Latency: 1 cycle from load to vld. Backpressure: none internally, owner gates load.
module pipe_skid_buf
  import pipe_stage_reg_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         unload,
  input  logic [W-1:0] d,
  output logic         vld,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (load) begin
      vld <= 1'b1;
      q   <= d;
    end else if (unload) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register, stall-vector (MODE=0) or valid/ready with skid (MODE=1).
// Latency: 1 cycle. Backpressure: MODE=0 via stall[STAGE]; MODE=1 in_ready drops when skid full.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                 DATA_W  = 32,
  parameter int                 STALL_W = CTRL_STALL_W,
  parameter int                 STAGE   = 2,
  parameter int                 MODE    = 0,
  parameter logic [DATA_W-1:0]  BUBBLE  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [STALL_W-1:0] stall,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_dslot_next,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_dslot_next,
  output logic [1:0]         occupancy
);

  logic              main_vld;
  logic [DATA_W-1:0] main_dat;
  logic              main_dslot;
  logic              nxt_vld;
  logic [DATA_W-1:0] nxt_dat;
  logic              nxt_dslot;
  logic              skid_vld;
  logic [DATA_W:0]   skid_dat;
  logic              skid_load;
  logic              skid_unload;
  logic              accept;
  logic              pop;

  assign in_ready = (MODE == 0) ? (stall[STAGE] == NO_STOP) : ~skid_vld;
  assign accept   = in_valid & in_ready;
  assign pop      = main_vld & out_ready;

  always_comb begin
    nxt_vld     = main_vld;
    nxt_dat     = main_dat;
    nxt_dslot   = main_dslot;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    if (MODE == 0) begin
      if (stall[STAGE] == NO_STOP) begin
        nxt_vld   = in_valid;
        nxt_dat   = in_data;
        nxt_dslot = in_dslot_next;
      end else if (stall[STAGE+1] == NO_STOP) begin
        // upstream frozen, downstream moving: inject a bubble, keep the delay-slot flag
        nxt_vld = 1'b0;
        nxt_dat = BUBBLE;
      end
    end else begin
      if (pop && skid_vld) begin
        // in_ready is low whenever the skid is full, so no accept can collide here
        nxt_vld              = 1'b1;
        {nxt_dslot, nxt_dat} = skid_dat;
        skid_unload          = 1'b1;
      end else if (accept && (!main_vld || pop)) begin
        nxt_vld   = 1'b1;
        nxt_dat   = in_data;
        nxt_dslot = in_dslot_next;
      end else if (accept) begin
        skid_load = 1'b1;
      end else if (pop) begin
        nxt_vld = 1'b0;
        nxt_dat = BUBBLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_vld   <= 1'b0;
      main_dat   <= BUBBLE;
      main_dslot <= 1'b0;
    end else begin
      main_vld   <= nxt_vld;
      main_dat   <= nxt_dat;
      main_dslot <= nxt_dslot;
    end
  end

  generate
    if (MODE == 1) begin : g_skid
      pipe_skid_buf #(.W(DATA_W + 1)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .clr    (flush),
        .load   (skid_load),
        .unload (skid_unload),
        .d      ({in_dslot_next, in_data}),
        .vld    (skid_vld),
        .q      (skid_dat)
      );
    end else begin : g_no_skid
      assign skid_vld = 1'b0;
      assign skid_dat = '0;
    end
  endgenerate

  // each mode leaves some of these inputs and strobes unused
  logic unused_mode_sigs;
  assign unused_mode_sigs = &{1'b0, stall, out_ready, skid_load, skid_unload, pop};

  assign out_valid      = main_vld;
  assign out_data       = main_dat;
  assign out_dslot_next = main_dslot;
  assign occupancy      = {1'b0, main_vld} + {1'b0, skid_vld};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: table-driven stall-mode vectors plus hand sequences for the skid mode.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // stall-vector mode DUT
  logic        s_rst, s_flush, s_in_valid, s_in_ready, s_in_dslot, s_out_valid, s_out_dslot;
  logic [5:0]  s_stall;
  logic [31:0] s_in_data, s_out_data;
  logic [1:0]  s_occ;

  pipe_stage_reg #(.DATA_W(32), .STALL_W(6), .STAGE(2), .MODE(0)) u_s (
    .clk(clk), .rst(s_rst), .flush(s_flush), .stall(s_stall),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .in_dslot_next(s_in_dslot), .out_valid(s_out_valid), .out_ready(1'b0),
    .out_data(s_out_data), .out_dslot_next(s_out_dslot), .occupancy(s_occ)
  );

  // handshake/skid mode DUT
  logic        h_rst, h_flush, h_in_valid, h_in_ready, h_in_dslot, h_out_valid, h_out_ready, h_out_dslot;
  logic [31:0] h_in_data, h_out_data;
  logic [1:0]  h_occ;

  pipe_stage_reg #(.DATA_W(32), .STALL_W(6), .STAGE(2), .MODE(1)) u_h (
    .clk(clk), .rst(h_rst), .flush(h_flush), .stall(6'h3f),
    .in_valid(h_in_valid), .in_ready(h_in_ready), .in_data(h_in_data),
    .in_dslot_next(h_in_dslot), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .out_data(h_out_data), .out_dslot_next(h_out_dslot), .occupancy(h_occ)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic [5:0]  stall;
    logic        vld;
    logic [31:0] dat;
    logic        ds;
    logic        e_ready;
    logic        e_vld;
    logic [31:0] e_dat;
    logic        e_ds;
    logic [1:0]  e_occ;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic f, input logic [5:0] st,
                              input logic v, input logic [31:0] d, input logic ds,
                              input logic er, input logic ev, input logic [31:0] ed,
                              input logic eds, input logic [1:0] eo);
    vec_t x;
    x.rst = r; x.flush = f; x.stall = st; x.vld = v; x.dat = d; x.ds = ds;
    x.e_ready = er; x.e_vld = ev; x.e_dat = ed; x.e_ds = eds; x.e_occ = eo;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  localparam int NV = 13;
  vec_t vt [NV];

  logic [31:0] exp_d [3];
  logic        exp_ds [3];
  logic [31:0] got_d [$];
  logic        got_ds [$];
  int sent;
  int seen;

  initial begin
    vt[0]  = mk(1'b1, 1'b0, 6'b000000, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 2'd0);
    vt[1]  = mk(1'b1, 1'b0, 6'b000000, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 2'd0);
    vt[2]  = mk(1'b0, 1'b0, 6'b000000, 1'b1, 32'h55,       1'b1, 1'b1, 1'b1, 32'h55,   1'b1, 2'd1);
    vt[3]  = mk(1'b0, 1'b0, 6'b000100, 1'b1, 32'h1234,     1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 2'd0);
    vt[4]  = mk(1'b0, 1'b0, 6'b000000, 1'b1, 32'h1234,     1'b0, 1'b1, 1'b1, 32'h1234, 1'b0, 2'd1);
    vt[5]  = mk(1'b0, 1'b0, 6'b000000, 1'b1, 32'hAA,       1'b1, 1'b1, 1'b1, 32'hAA,   1'b1, 2'd1);
    vt[6]  = mk(1'b0, 1'b0, 6'b001100, 1'b0, 32'hBB,       1'b0, 1'b0, 1'b1, 32'hAA,   1'b1, 2'd1);
    vt[7]  = mk(1'b0, 1'b0, 6'b001100, 1'b0, 32'hBB,       1'b0, 1'b0, 1'b1, 32'hAA,   1'b1, 2'd1);
    vt[8]  = mk(1'b0, 1'b0, 6'b001100, 1'b0, 32'hBB,       1'b0, 1'b0, 1'b1, 32'hAA,   1'b1, 2'd1);
    vt[9]  = mk(1'b0, 1'b1, 6'b000000, 1'b1, 32'hCC,       1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 2'd0);
    vt[10] = mk(1'b0, 1'b0, 6'b000000, 1'b0, 32'h77,       1'b0, 1'b1, 1'b0, 32'h77,   1'b0, 2'd0);
    vt[11] = mk(1'b0, 1'b0, 6'b000011, 1'b1, 32'h99,       1'b0, 1'b1, 1'b1, 32'h99,   1'b0, 2'd1);
    vt[12] = mk(1'b0, 1'b0, 6'b111000, 1'b1, 32'h5A,       1'b1, 1'b1, 1'b1, 32'h5A,   1'b1, 2'd1);

    s_rst = 1'b1; s_flush = 1'b0; s_stall = '0; s_in_valid = 1'b0; s_in_data = '0; s_in_dslot = 1'b0;
    h_rst = 1'b1; h_flush = 1'b0; h_in_valid = 1'b0; h_in_data = '0; h_in_dslot = 1'b0; h_out_ready = 1'b0;

    // stall-vector mode
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      s_rst = vt[i].rst; s_flush = vt[i].flush; s_stall = vt[i].stall;
      s_in_valid = vt[i].vld; s_in_data = vt[i].dat; s_in_dslot = vt[i].ds;
      #1;
      chk($sformatf("m0[%0d] in_ready", i), {31'b0, s_in_ready}, {31'b0, vt[i].e_ready});
      @(posedge clk);
      #1;
      chk($sformatf("m0[%0d] out_valid", i), {31'b0, s_out_valid}, {31'b0, vt[i].e_vld});
      chk($sformatf("m0[%0d] out_data", i), s_out_data, vt[i].e_dat);
      chk($sformatf("m0[%0d] out_dslot", i), {31'b0, s_out_dslot}, {31'b0, vt[i].e_ds});
      chk($sformatf("m0[%0d] occupancy", i), {30'b0, s_occ}, {30'b0, vt[i].e_occ});
    end

    // skid mode: reset with traffic offered
    h_rst = 1'b1; h_in_valid = 1'b1; h_in_data = 32'hDEADBEEF; h_in_dslot = 1'b1;
    cyc(); cyc();
    chk("m1 rst occ", {30'b0, h_occ}, 32'd0);
    chk("m1 rst valid", {31'b0, h_out_valid}, 32'd0);
    chk("m1 rst data", h_out_data, 32'h0);
    chk("m1 rst dslot", {31'b0, h_out_dslot}, 32'd0);
    chk("m1 rst in_ready", {31'b0, h_in_ready}, 32'd1);

    // fill main and skid with out_ready low
    h_rst = 1'b0; h_in_data = 32'h11; h_in_dslot = 1'b1;
    cyc();
    chk("m1 fill1 data", h_out_data, 32'h11);
    chk("m1 fill1 occ", {30'b0, h_occ}, 32'd1);
    h_in_data = 32'h22; h_in_dslot = 1'b0;
    cyc();
    chk("m1 fill2 occ", {30'b0, h_occ}, 32'd2);
    chk("m1 fill2 in_ready", {31'b0, h_in_ready}, 32'd0);
    h_in_data = 32'h33; h_in_dslot = 1'b1;
    cyc();
    chk("m1 held occ", {30'b0, h_occ}, 32'd2);
    chk("m1 held data", h_out_data, 32'h11);

    // drain in order
    exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33;
    exp_ds[0] = 1'b1;  exp_ds[1] = 1'b0;  exp_ds[2] = 1'b1;
    h_out_ready = 1'b1;
    sent = 2;
    for (int n = 0; n < 20; n++) begin
      h_in_valid = (sent < 3);
      h_in_data  = exp_d[2];
      h_in_dslot = exp_ds[2];
      if (h_out_valid && h_out_ready) begin
        got_d.push_back(h_out_data);
        got_ds.push_back(h_out_dslot);
      end
      if (h_in_valid && h_in_ready) sent++;
      cyc();
      if (sent == 3 && got_d.size() == 3 && !h_out_valid) break;
    end
    chk("m1 drain count", got_d.size(), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < got_d.size()) begin
        chk($sformatf("m1 drain[%0d] data", k), got_d[k], exp_d[k]);
        chk($sformatf("m1 drain[%0d] dslot", k), {31'b0, got_ds[k]}, {31'b0, exp_ds[k]});
      end
    end
    h_in_valid = 1'b0;
    cyc();
    chk("m1 drained occ", {30'b0, h_occ}, 32'd0);

    // flush with skid full
    h_out_ready = 1'b0; h_in_valid = 1'b1; h_in_data = 32'h55;
    cyc();
    h_in_data = 32'h66;
    cyc();
    chk("m1 refill occ", {30'b0, h_occ}, 32'd2);
    h_flush = 1'b1; h_in_data = 32'h44;
    cyc();
    chk("m1 flush occ", {30'b0, h_occ}, 32'd0);
    chk("m1 flush valid", {31'b0, h_out_valid}, 32'd0);
    chk("m1 flush data", h_out_data, 32'h0);
    h_flush = 1'b0; h_in_valid = 1'b0; h_out_ready = 1'b1;
    seen = 0;
    for (int n = 0; n < 3; n++) begin
      cyc();
      if (h_out_valid) seen++;
    end
    chk("m1 post-flush outputs", seen, 32'd0);

    // flush while an offered entry would be accepted
    h_out_ready = 1'b0; h_in_valid = 1'b1; h_in_data = 32'h50;
    cyc();
    chk("m1 single occ", {30'b0, h_occ}, 32'd1);
    h_flush = 1'b1; h_in_data = 32'h44;
    chk("m1 flush in_ready", {31'b0, h_in_ready}, 32'd1);
    cyc();
    h_flush = 1'b0; h_in_valid = 1'b0;
    chk("m1 flush1 occ", {30'b0, h_occ}, 32'd0);
    cyc();
    chk("m1 flush1 valid", {31'b0, h_out_valid}, 32'd0);

    // full-throughput stream
    h_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      h_in_valid = 1'b1; h_in_data = 32'h100 + 32'(i); h_in_dslot = i[0];
      cyc();
      chk($sformatf("m1 stream[%0d] data", i), h_out_data, 32'h100 + 32'(i));
      chk($sformatf("m1 stream[%0d] valid", i), {31'b0, h_out_valid}, 32'd1);
      chk($sformatf("m1 stream[%0d] occ", i), {30'b0, h_occ}, 32'd1);
    end
    h_in_valid = 1'b0;
    cyc();
    chk("m1 pop bubble valid", {31'b0, h_out_valid}, 32'd0);
    chk("m1 pop bubble data", h_out_data, 32'h0);

    // reset while skid full drops both entries
    h_out_ready = 1'b0; h_in_valid = 1'b1; h_in_data = 32'h61;
    cyc();
    h_in_data = 32'h62;
    cyc();
    chk("m1 prerst occ", {30'b0, h_occ}, 32'd2);
    h_rst = 1'b1; h_in_valid = 1'b0;
    cyc();
    chk("m1 midrst occ", {30'b0, h_occ}, 32'd0);
    chk("m1 midrst in_ready", {31'b0, h_in_ready}, 32'd1);
    h_rst = 1'b0; h_out_ready = 1'b1;
    cyc();
    chk("m1 postrst valid", {31'b0, h_out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
